// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - direction codes shared by the key queue and the snake mover
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  // Opposite directions differ only in bit 0 (up/down, left/right).
  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  function automatic logic dir_conflicts(input dir_t cand, input dir_t last);
    return (cand == last) || (cand == dir_opposite(last));
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, counter debounce and rising-edge pulse for one key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= key;
      sync_q2 <= sync_q1;
      deb_q   <= deb;
      press   <= deb & ~deb_q;
      // Any cycle where the levels agree restarts the stability count.
      if (sync_q2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync_q2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_dir_queue.sv
// rtl/key_dir_queue.sv - four debounced keys, direction arbitration/filter and a show-ahead queue
module key_dir_queue #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       left,
  input  logic                       right,
  input  logic                       up,
  input  logic                       down,
  output logic                       left_key_press,
  output logic                       right_key_press,
  output logic                       up_key_press,
  output logic                       down_key_press,
  output logic                       dir_valid,
  output logic [1:0]                 dir_code,
  input  logic                       dir_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       dropped
);

  import snake_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left  (.clk(clk), .rst(rst), .key(left),  .press(left_key_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (.clk(clk), .rst(rst), .key(right), .press(right_key_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up    (.clk(clk), .rst(rst), .key(up),    .press(up_key_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down  (.clk(clk), .rst(rst), .key(down),  .press(down_key_press));

  dir_t          mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  dir_t          last_dir;

  logic cand_valid;
  dir_t cand;
  logic accept;
  logic full;
  logic pop;
  logic push;

  always_comb begin
    cand_valid = 1'b1;
    cand       = DIR_UP;
    if (left_key_press)       cand = DIR_LEFT;
    else if (right_key_press) cand = DIR_RIGHT;
    else if (up_key_press)    cand = DIR_UP;
    else if (down_key_press)  cand = DIR_DOWN;
    else                      cand_valid = 1'b0;
  end

  assign dir_valid = (level != '0);
  assign dir_code  = dir_valid ? mem[rptr] : DIR_UP;
  assign full      = (level == LW'(DEPTH));
  assign pop       = dir_valid && dir_ready;
  // A full queue still accepts a push when the consumer frees a slot this cycle.
  assign accept    = cand_valid && !dir_conflicts(cand, last_dir);
  assign push      = accept && (!full || pop);
  assign dropped   = accept && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DIR_UP;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      last_dir <= DIR_RIGHT;
    end else begin
      if (push) begin
        mem[wptr] <= cand;
        wptr      <= wptr + PW'(1);
        last_dir  <= cand;
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_key_dir_queue.sv
// tb/tb_key_dir_queue.sv - self-checking bench for key_dir_queue with a queue-level reference model
module tb_key_dir_queue;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] keys = 4'b0000;  // 0 left, 1 right, 2 up, 3 down
  logic       dir_ready = 1'b0;
  logic       left_kp, right_kp, up_kp, down_kp;
  logic       dir_valid;
  logic [1:0] dir_code;
  logic [2:0] level;
  logic       dropped;
  logic [3:0] dut_press;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_dir_queue #(.DEBOUNCE_CYCLES(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .left(keys[0]), .right(keys[1]), .up(keys[2]), .down(keys[3]),
    .left_key_press(left_kp), .right_key_press(right_kp),
    .up_key_press(up_kp), .down_key_press(down_kp),
    .dir_valid(dir_valid), .dir_code(dir_code), .dir_ready(dir_ready),
    .level(level), .dropped(dropped)
  );

  assign dut_press = {down_kp, up_kp, right_kp, left_kp};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: raw levels seen two edges late, a level change accepted after
  // D consecutive disagreeing cycles, pulse one cycle later, queue kept as an SV queue.
  logic [1:0] kcode [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
  bit         m_h1 [4], m_h2 [4], m_deb [4], m_rose [4], m_press [4];
  int         m_run [4];
  logic [1:0] m_last = 2'b11;
  logic [1:0] m_q [$];

  always @(posedge clk or negedge rst) begin : model
    logic       cv;
    logic [1:0] c;
    logic       pop;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        m_h1[k] = 0; m_h2[k] = 0; m_deb[k] = 0; m_rose[k] = 0; m_press[k] = 0; m_run[k] = 0;
      end
      m_last = 2'b11;
      m_q.delete();
    end else begin
      cv = 1'b0;
      c  = 2'b00;
      for (int k = 0; k < 4; k++) if (m_press[k] && !cv) begin cv = 1'b1; c = kcode[k]; end
      pop = (m_q.size() != 0) && dir_ready;
      if (pop) void'(m_q.pop_front());
      if (cv && (c[1] != m_last[1]) && m_q.size() < DEPTH) begin
        m_q.push_back(c);
        m_last = c;
      end
      for (int k = 0; k < 4; k++) begin
        m_press[k] = m_rose[k];
        m_rose[k]  = 0;
        if (m_h2[k] != m_deb[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_deb[k]  = m_h2[k];
            m_rose[k] = m_h2[k];
            m_run[k]  = 0;
          end
        end else begin
          m_run[k] = 0;
        end
        m_h2[k] = m_h1[k];
        m_h1[k] = keys[k];
      end
    end
  end

  always @(negedge clk) begin : compare
    logic       cv;
    logic [1:0] c;
    logic       full_np;
    cv = 1'b0;
    c  = 2'b00;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("press[%0d]", k), {31'b0, dut_press[k]}, {31'b0, m_press[k]});
      if (m_press[k] && !cv) begin cv = 1'b1; c = kcode[k]; end
    end
    full_np = (m_q.size() == DEPTH) && !dir_ready;
    chk("level", {29'b0, level}, m_q.size());
    chk("dir_valid", {31'b0, dir_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) chk("dir_code", {30'b0, dir_code}, {30'b0, m_q[0]});
    chk("dropped", {31'b0, dropped}, {31'b0, cv && (c[1] != m_last[1]) && full_np});
  end

  int pc [4] = '{0, 0, 0, 0};
  int drop_cnt = 0;
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (dut_press[k]) pc[k]++;
    if (dropped) drop_cnt++;
  end

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic press_key(input int k, input int hold);
    @(posedge clk); #2 keys[k] = 1'b1;
    repeat (hold) @(posedge clk);
    #2 keys[k] = 1'b0;
    repeat (10) @(posedge clk);
    #2;
  endtask

  initial begin
    int first;
    int snap;
    int snap_all;
    int sd;
    logic [1:0] pops [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_level", {29'b0, level}, 0);
    chk("reset_dir_code", {30'b0, dir_code}, 0);

    // Held up: one pulse, dir_valid 8 edges after the input edge, head 00.
    snap  = pc[2];
    first = 0;
    @(posedge clk); #2 keys[2] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (dir_valid && first == 0) first = i;
    end
    chk("up_latency", first, 8);
    chk("up_head", {30'b0, dir_code}, 2'b00);
    @(posedge clk); #2 keys[2] = 1'b0;
    repeat (10) @(posedge clk);
    #2 chk("up_one_pulse", pc[2] - snap, 1);

    // Bouncing down never settles long enough.
    do_reset();
    snap = pc[3];
    for (int i = 0; i < 10; i++) begin
      keys[3] = ~keys[3];
      repeat (2) @(posedge clk);
      #2;
    end
    repeat (10) @(posedge clk);
    #2 chk("bounce_no_pulse", pc[3] - snap, 0);
    chk("bounce_level", {29'b0, level}, 0);

    // Opposite and same as the initial heading are filtered.
    do_reset();
    snap = pc[0];
    press_key(0, 10);
    chk("left_pulse", pc[0] - snap, 1);
    chk("left_filtered", {29'b0, level}, 0);
    snap = pc[1];
    press_key(1, 10);
    chk("right_pulse", pc[1] - snap, 1);
    chk("right_filtered", {29'b0, level}, 0);

    // Fill, overflow once, then drain in order.
    do_reset();
    sd = drop_cnt;
    press_key(2, 10);
    press_key(0, 10);
    press_key(3, 10);
    press_key(1, 10);
    press_key(2, 10);
    press_key(0, 10);
    chk("full_level", {29'b0, level}, 4);
    chk("drop_once", drop_cnt - sd, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("pop%0d", i), {30'b0, dir_code}, {30'b0, pops[i]});
      @(posedge clk); #2 dir_ready = 1'b1;
      @(posedge clk); #2 dir_ready = 1'b0;
    end
    #1 chk("drained", {29'b0, level}, 0);

    // Simultaneous left+up: only left queued; then full + pop in the push cycle.
    do_reset();
    press_key(3, 10);
    @(posedge clk); #2 keys[0] = 1'b1; keys[2] = 1'b1;
    repeat (10) @(posedge clk);
    #2 keys[0] = 1'b0; keys[2] = 1'b0;
    repeat (10) @(posedge clk);
    #2 chk("simul_level", {29'b0, level}, 2);
    press_key(2, 10);
    press_key(0, 10);
    chk("refill_level", {29'b0, level}, 4);
    sd = drop_cnt;
    @(posedge clk); #2 keys[2] = 1'b1;
    repeat (7) @(posedge clk);
    #2 dir_ready = 1'b1;
    @(negedge clk);
    chk("push_cycle_pulse", {31'b0, up_kp}, 1);
    @(posedge clk); #2 dir_ready = 1'b0;
    chk("push_pop_level", {29'b0, level}, 4);
    chk("push_pop_head", {30'b0, dir_code}, 2'b10);
    keys[2] = 1'b0;
    repeat (10) @(posedge clk);
    #2 chk("push_pop_no_drop", drop_cnt - sd, 0);

    // Reset mid-debounce with three entries queued.
    do_reset();
    press_key(2, 10);
    press_key(0, 10);
    press_key(3, 10);
    chk("pre_reset_level", {29'b0, level}, 3);
    @(posedge clk); #2 keys[1] = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("async_level", {29'b0, level}, 0);
    chk("async_valid", {31'b0, dir_valid}, 0);
    keys[1] = 1'b0;
    snap_all = pc[0] + pc[1] + pc[2] + pc[3];
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (15) @(posedge clk);
    #2 chk("no_pulse_after_reset", pc[0] + pc[1] + pc[2] + pc[3] - snap_all, 0);
    press_key(1, 10);
    chk("last_dir_reset_right", {29'b0, level}, 0);

    // Key held through reset release gives exactly one press.
    @(posedge clk); #2 rst = 1'b0; keys[3] = 1'b1;
    snap = pc[3];
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (12) @(posedge clk);
    #2 chk("held_through_reset", pc[3] - snap, 1);
    chk("held_push", {29'b0, level}, 1);
    keys[3] = 1'b0;
    repeat (10) @(posedge clk);

    #2 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_dir_queue.md
KEY_DIR_QUEUE -- requirements
Module: key_dir_queue

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of stable synchronized cycles needed to accept a key level change.
REQ-002 Parameter DEPTH, default 4, is the number of direction-queue entries; it SHALL be a power of two and at least 2.
REQ-003 Port clk  input  1  is the single system clock; all logic is on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-low reset.
REQ-005 Ports left, right, up, down  input  1 each  are raw, active-high, bouncing push-button levels.
REQ-006 Ports left_key_press, right_key_press, up_key_press, down_key_press  output  1 each  give a one-cycle pulse per debounced press.
REQ-007 Port dir_valid  output  1  means the queue head holds a direction.
REQ-008 Port dir_code  output  2  is the head direction: 00 up, 01 down, 10 left, 11 right.
REQ-009 Port dir_ready  input  1  is the consumer pop request.
REQ-010 Port level  output  $clog2(DEPTH+1)  is the current occupancy.
REQ-011 Port dropped  output  1  gives a one-cycle pulse when an accepted press is lost because the queue is full.

Function
REQ-012 Each raw key SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Per key, a counter SHALL clear whenever the synchronized level equals the debounced level, and SHALL otherwise increment.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-015 A *_key_press pulse SHALL assert for exactly one cycle, in the cycle after the debounced level rises 0->1; a release SHALL generate no pulse.
REQ-016 For pulses in the same cycle, priority SHALL be left > right > up > down; only the winner is a candidate and the losers are discarded.
REQ-017 A candidate SHALL be rejected (no push, no dropped) when it equals last_dir or is the exact opposite of last_dir.
REQ-018 last_dir SHALL update only on a successful push.
REQ-019 A non-rejected candidate SHALL be pushed in the cycle after its press pulse when level < DEPTH, or when level == DEPTH and a pop occurs in that same cycle.
REQ-020 A non-rejected candidate that cannot be pushed SHALL pulse dropped in that cycle and SHALL leave last_dir unchanged.
REQ-021 The queue SHALL be show-ahead: dir_valid = (level != 0), and dir_code = head entry combinationally from registers.
REQ-022 A pop SHALL occur when dir_valid && dir_ready; dir_ready while empty SHALL have no effect.
REQ-023 A simultaneous push and pop SHALL leave level unchanged; when level == 1, the pushed entry SHALL become the head in the next cycle.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow.
REQ-025 Latency from a raw stable press to dir_valid on an empty queue SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 (pulse) + 1 (push) cycles.

Reset
REQ-026 While rst is low: synchronizers, debounced levels and counters = 0; all press pulses = 0; level = 0; dir_valid = 0; dir_code = 00; dropped = 0; pointers = 0; last_dir = 11 (right, the initial snake heading).
REQ-027 Reset asserted mid-operation SHALL discard all queued entries and in-progress debounce counts immediately.
REQ-028 After reset release, a key already held high SHALL produce one press pulse once it is debounced.

Structure
REQ-029 Direction codes (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT) and a 2-bit direction typedef SHALL reside in the shared snake_pkg package, which is also used by the snake mover.
REQ-030 Per-key synchronize/debounce/edge logic SHALL be one sub-module, key_debounce, instantiated four times; arbitration, filtering and the FIFO reside in key_dir_queue.

Verification (DEBOUNCE_CYCLES=4, DEPTH=4)
REQ-031 Reset, then hold up high for 10 cycles: exactly one up_key_press pulse; dir_valid rises 8 cycles after the input edge with dir_code=00.
REQ-032 Toggle down every 2 cycles for 20 cycles, then hold low: no down_key_press pulse and level stays 0.
REQ-033 From reset, press left (opposite of right) and then right (same as last_dir): no pushes; press pulses still occur; level=0.
REQ-034 With dir_ready=0, press up, left, down, right, up, left in turn: level reaches 4 and holds, and dropped pulses once; popping then yields 00, 10, 01, 11.
REQ-035 left and up debounced in the same cycle: only 10 is queued; then, with level=4, a new press plus dir_ready=1 in the push cycle leaves level=4 and dropped=0.
REQ-036 Pull rst low while level=3 mid-debounce: level=0 and dir_valid=0 immediately, last_dir=11, and no pulse follows release unless a key is held.
